// File: rtl/ccff_loader.sv
// Serialises a word-wide bitstream into a ccff configuration chain, MSB first, while counting
// the ones that fall out of the chain tail (popcount of the previous configuration).
module ccff_loader #(
  parameter int unsigned CHAIN_LEN = 160,
  parameter int unsigned WORD_W    = 8
) (
  input  logic                               prog_clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic                               abort,
  input  logic [WORD_W-1:0]                  word_data,
  input  logic                               word_valid,
  output logic                               word_ready,
  output logic                               ccff_head,
  output logic                               ccff_shift_en,
  input  logic                               ccff_tail,
  output logic                               busy,
  output logic                               done,
  output logic                               err,
  output logic [$clog2(CHAIN_LEN+1)-1:0]     tail_ones
);

  localparam int unsigned CntW = $clog2(CHAIN_LEN + 1);
  localparam int unsigned RemW = $clog2(WORD_W + 1);
  localparam logic [CntW-1:0] LastIdx = CntW'(CHAIN_LEN - 1);
  localparam logic [CntW-1:0] MaxOnes = CntW'(CHAIN_LEN);

  typedef enum logic [1:0] {StIdle, StLoad, StFinish} state_e;

  state_e            state_q;
  logic [WORD_W-1:0] buf_q;
  logic [RemW-1:0]   rem_q;
  logic [CntW-1:0]   bit_cnt_q;
  logic [CntW-1:0]   tail_ones_q;
  logic              done_q;
  logic              err_q;

  logic shift;
  logic last;
  logic accept;

  always_comb begin
    shift         = (state_q == StLoad) && (rem_q != '0) && !abort;
    last          = shift && (bit_cnt_q == LastIdx);
    // A new word may land on the same edge that shifts out the last buffered bit, unless that
    // bit also completes the chain.
    word_ready    = (state_q == StLoad) && !abort &&
                    ((rem_q == '0) || ((rem_q == RemW'(1)) && shift && !last));
    accept        = word_valid && word_ready;
    ccff_shift_en = shift;
    ccff_head     = shift && buf_q[WORD_W-1];
    busy          = (state_q != StIdle);
    done          = done_q;
    err           = err_q;
    tail_ones     = tail_ones_q;
  end

  always_ff @(posedge prog_clk) begin
    if (reset) begin
      state_q     <= StIdle;
      buf_q       <= '0;
      rem_q       <= '0;
      bit_cnt_q   <= '0;
      tail_ones_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q     <= StLoad;
            rem_q       <= '0;
            bit_cnt_q   <= '0;
            tail_ones_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
          end
        end
        StLoad: begin
          if (abort) begin
            state_q <= StIdle;
            rem_q   <= '0;
            err_q   <= 1'b1;
            done_q  <= 1'b0;
          end else begin
            if (shift) begin
              buf_q     <= buf_q << 1;
              rem_q     <= rem_q - RemW'(1);
              bit_cnt_q <= bit_cnt_q + CntW'(1);
              if (ccff_tail && (tail_ones_q != MaxOnes)) begin
                tail_ones_q <= tail_ones_q + CntW'(1);
              end
            end
            if (accept) begin
              buf_q <= word_data;
              rem_q <= RemW'(WORD_W);
            end
            if (last) begin
              state_q <= StFinish;
              rem_q   <= '0;
            end
          end
        end
        StFinish: begin
          state_q <= StIdle;
          if (abort) begin
            err_q  <= 1'b1;
            done_q <= 1'b0;
          end else begin
            done_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/ccff_loader.md
CCFF_LOADER -- requirements
Module: ccff_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 160: number of configuration bits in the downstream ccff chain (min 1).
REQ-002 SHALL have parameter WORD_W, default 8: bitstream word width (min 1).
REQ-003 SHALL provide prog_clk  input  1  single clock for all logic.
REQ-004 SHALL provide reset  input  1  synchronous, active-high reset.
REQ-005 SHALL provide start  input  1  one-cycle request to begin a chain load.
REQ-006 SHALL provide abort  input  1  terminate an in-progress load.
REQ-007 SHALL provide word_data  input  WORD_W  bitstream word, MSB shifted first.
REQ-008 SHALL provide word_valid  input  1  word_data is valid.
REQ-009 SHALL provide word_ready  output  1  loader accepts word this cycle.
REQ-010 SHALL provide ccff_head  output  1  serial bit into chain.
REQ-011 SHALL provide ccff_shift_en  output  1  chain shift enable, for the prog_clk gating cell.
REQ-012 SHALL provide ccff_tail  input  1  serial bit out of chain.
REQ-013 SHALL provide busy  output  1  load in progress.
REQ-014 SHALL provide done  output  1  last load completed; level output.
REQ-015 SHALL provide err  output  1  last load aborted; level output.
REQ-016 SHALL provide tail_ones  output  clog2(CHAIN_LEN+1)  count of 1s sampled on ccff_tail during the last load, i.e. the popcount of the prior configuration.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD and FINISH.
REQ-018 IDLE: start=1 -> LOAD; bit_cnt, tail_ones, done and err cleared on the same edge.
REQ-019 start SHALL be ignored in LOAD and FINISH.
REQ-020 Word buffer: WORD_W-bit shift register plus remaining-bit counter rem.
REQ-021 word_ready SHALL be 1 only in LOAD when rem==0 or rem==1 and a shift occurs this cycle; back-to-back words then shift with no bubble.
REQ-022 A word SHALL be accepted when word_valid&&word_ready; it is latched and rem=WORD_W at that edge.
REQ-023 Shifting SHALL begin in the following cycle.
REQ-024 Shift cycle: in LOAD with rem>0, ccff_shift_en=1 and ccff_head=buffer MSB.
REQ-025 At the end of each shift cycle: buffer shifts left, rem decrements, bit_cnt increments, and tail_ones increments if ccff_tail==1.
REQ-026 In all other cycles, ccff_shift_en=0 and ccff_head=0.
REQ-027 Shift cycles SHALL occur exactly CHAIN_LEN times per load.
REQ-028 When bit_cnt reaches CHAIN_LEN-1 on a shift: the FSM goes to FINISH, the remaining buffer bits are discarded (rem=0), and word_ready=0 thereafter.
REQ-029 A gap in word_valid SHALL stall shifting with ccff_shift_en=0; there is no timeout.
REQ-030 FINISH SHALL last one cycle, then IDLE with done=1.
REQ-031 busy SHALL be 1 in LOAD and FINISH.
REQ-032 abort=1 in LOAD or FINISH SHALL, on the next edge: go to IDLE, set err=1 and done=0, clear rem, and suppress any shift or word acceptance that cycle; ccff_shift_en=0 in the abort cycle.
REQ-033 abort in IDLE SHALL have no effect.
REQ-034 tail_ones SHALL saturate at CHAIN_LEN.
REQ-035 tail_ones SHALL hold its value in IDLE until the next start.
REQ-036 If start and abort are both high in IDLE, start SHALL win.

Reset
REQ-037 reset=1 SHALL force, on the next prog_clk edge: IDLE, rem=0, bit_cnt=0, tail_ones=0, busy=0, done=0, err=0, word_ready=0, ccff_head=0, ccff_shift_en=0.
REQ-038 Reset mid-load SHALL discard all partial state and produce no further shifts.
REQ-039 reset SHALL take priority over start and abort.

Verification
REQ-040 Full load (CHAIN_LEN=16, WORD_W=8): start, then words 0xA5, 0x3C with valid held -> exactly 16 consecutive ccff_shift_en cycles; ccff_head = 1010010100111100; done=1 one cycle after the last shift; busy=0.
REQ-041 Partial final word (CHAIN_LEN=12): words 0xFF, 0x0F -> 12 shifts, head = 111111110000; low nibble of 0x0F never shifted.
REQ-042 Stall: word_valid deasserted for 5 cycles between words -> ccff_shift_en=0 for those cycles; bit order unchanged; total shifts = CHAIN_LEN.
REQ-043 Readback count: model chain preloaded with 0xF00F, driven onto ccff_tail -> tail_ones=8 after load.
REQ-044 Abort after 5 shifts -> IDLE next edge; err=1, done=0, busy=0, no further shifts. Subsequent start clears err.
REQ-045 Reset asserted mid-word (rem=3) -> all outputs at reset values next edge; start after reset performs a clean full load.
